wb_master_bridge: RTL

Wishbone B4 classic-cycle initiator that converts a simple valid/ready command/response interface into single-beat Wishbone read and write cycles. It sits between an internal requester (test sequencer, DMA engine, CPU load/store unit) and any Wishbone B4 responder, such as the single-port memory Wishbone wrapper. It also provides bus-error reporting and a watchdog timeout, so an absent or hung slave cannot stall the requester.

---
 rtl/wb_master_pkg.sv | 19 +
 rtl/wb_timeout_cnt.sv | 51 +++++
 rtl/wb_master_bridge.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/wb_master_pkg.sv
// Shared types and constants for the Wishbone B4 classic-cycle initiator.
package wb_master_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  // Watchdog length used when the integrator does not override it.
  localparam int TIMEOUT_DEFAULT = 255;

  // Counter width able to hold TIMEOUT-1; never narrower than one bit so a
  // disabled watchdog still elaborates cleanly.
  function automatic int cnt_width(input int t);
    return (t <= 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Bus-cycle watchdog: counts stalled BUS cycles and flags the last allowed one.
// With TIMEOUT=0 the counter is removed and expire_o is tied low.
module wb_timeout_cnt
  import wb_master_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = cnt_width(TIMEOUT);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expire_o = 1'b0;
    end else begin : g_on
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
      localparam logic [CW-1:0] SAT  = {CW{1'b1}};

      logic [CW-1:0] cnt_q, cnt_d;

      // Clear wins over enable; increment saturates so the count cannot wrap.
      always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
          cnt_d = '0;
        end else if (en_i && (cnt_q != SAT)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // Counter register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      // Expiry is seen on the same edge that would otherwise advance past TIMEOUT-1,
      // so stb_o stays high for exactly TIMEOUT cycles.
      assign expire_o = (cnt_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/wb_master_bridge.sv
// Valid/ready command/response to Wishbone B4 classic single-beat initiator,
// with bus-error reporting and a watchdog that aborts hung cycles.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// BUS   | cyc_o/stb_o high, waiting for ack_i, err_i or watchdog expiry
// RESP  | rsp_valid high, fields held until rsp_ready
module wb_master_bridge
  import wb_master_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_we,
  input  logic [31:0]        cmd_addr,
  input  logic [WIDTH-1:0]   cmd_wdata,
  input  logic [WIDTH/8-1:0] cmd_sel,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_rdata,
  output logic               rsp_err,
  output logic               rsp_timeout,
  output logic [31:0]        adr_o,
  output logic [WIDTH-1:0]   dat_o,
  output logic [WIDTH/8-1:0] sel_o,
  output logic               we_o,
  output logic               cyc_o,
  output logic               stb_o,
  input  logic [WIDTH-1:0]   dat_i,
  input  logic               ack_i,
  input  logic               err_i
);

  localparam int SW = WIDTH / 8;

  state_e           state_q, state_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rsp_tmo_q, rsp_tmo_d;
  logic [31:0]      adr_q, adr_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic             we_q, we_d;
  logic             cyc_q, cyc_d;
  logic             stb_q, stb_d;

  logic accept;
  logic tmo_en;
  logic tmo_expire;

  assign accept = (state_q == IDLE) && cmd_valid && cmd_ready_q;
  // Only stalled BUS cycles advance the watchdog.
  assign tmo_en = (state_q == BUS) && !ack_i && !err_i;

  wb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (accept),
    .en_i     (tmo_en),
    .expire_o (tmo_expire)
  );

  // Next-state and registered-output values; priority in BUS is err, ack, timeout.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_tmo_d   = rsp_tmo_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    we_d        = we_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          adr_d   = cmd_addr;
          dat_d   = cmd_wdata;
          sel_d   = cmd_sel;
          we_d    = cmd_we;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        if (err_i) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_tmo_d   = 1'b0;
          rsp_valid_d = 1'b1;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          state_d     = RESP;
        end else if (ack_i) begin
          rsp_rdata_d = we_q ? '0 : dat_i;
          rsp_err_d   = 1'b0;
          rsp_tmo_d   = 1'b0;
          rsp_valid_d = 1'b1;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          state_d     = RESP;
        end else if (tmo_expire) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_tmo_d   = 1'b1;
          rsp_valid_d = 1'b1;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_tmo_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        state_d = IDLE;
      end
    endcase

    // Registered ready: low from the accept edge until the response handshake.
    cmd_ready_d = (state_d == IDLE);
  end

  // State and output registers; reset drops cyc_o/stb_o immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tmo_q   <= rsp_tmo_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_tmo_q;
  assign adr_o       = adr_q;
  assign dat_o       = dat_q;
  assign sel_o       = sel_q;
  assign we_o        = we_q;
  assign cyc_o       = cyc_q;
  assign stb_o       = stb_q;

endmodule
